// File: rtl/icache_refill_ctrl_if.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl_if
//
// Burst-read bus between the I-cache refill controller and the memory side.
// The controller issues one line-aligned burst per miss and then receives the
// returning 64-bit beats.
//
//   mem_req     controller -> memory  burst read request, held until mem_gnt
//   mem_addr    controller -> memory  line-aligned burst base address
//   mem_gnt     memory -> controller  request accepted
//   mem_rvalid  memory -> controller  read beat valid
//   mem_rdata   memory -> controller  read beat data
//
// Modports: master = refill controller, slave = memory / bus fabric.
// -----------------------------------------------------------------------------
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );

endinterface : icache_refill_ctrl_if

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//
// Miss/refill sequencer for an 8-way, 64-set, 64 B-line instruction cache.
// A fetch miss stalls the IF stage, issues one line-aligned 8-beat burst read,
// writes each returning beat into the victim way, and commits tag+valid only
// after the final beat, so a partially filled line can never hit. Victims are
// chosen by a per-set round-robin pointer.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   fetch_req    IF fetch request this cycle
//   fetch_addr   fetch byte address
//   cache_hit    combinational hit from the tag compare
//   fetch_stall  hold PC/IF pipeline (combinational, asserts in the miss cycle)
//   bus          memory burst interface (master side)
//   fill_we      write one data word into the cache (pass-through of rvalid)
//   fill_set     target set
//   fill_way     target way
//   fill_word    word index within the line
//   fill_data    word data (pass-through of mem_rdata)
//   fill_tag_we  commit tag and set valid for (fill_set, fill_way)
//   fill_tag     tag to commit
//   miss_count   saturating miss counter
// -----------------------------------------------------------------------------
module icache_refill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int SETS        = 64,
  parameter int WAYS        = 8,
  parameter int OFFSET_BITS = 6,
  parameter int BEATS       = 8,
  parameter int TAG_BITS    = ADDR_W - 6 - OFFSET_BITS
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  input  logic                     cache_hit,
  output logic                     fetch_stall,

  icache_refill_ctrl_if.master     bus,

  output logic                     fill_we,
  output logic [$clog2(SETS)-1:0]  fill_set,
  output logic [$clog2(WAYS)-1:0]  fill_way,
  output logic [$clog2(BEATS)-1:0] fill_word,
  output logic [63:0]              fill_data,
  output logic                     fill_tag_we,
  output logic [TAG_BITS-1:0]      fill_tag,
  output logic [31:0]              miss_count
);

  localparam int SET_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int BEAT_W = $clog2(BEATS);

  // Clears the byte-offset bits to form the line-aligned burst address.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    COMMIT
  } state_t;

  state_t              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [WAY_W-1:0]    rr_ptr_q [SETS];
  logic [SET_W-1:0]    fill_set_q;
  logic [WAY_W-1:0]    fill_way_q;
  logic [TAG_BITS-1:0] fill_tag_q;
  logic                fill_tag_we_q;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         miss_cnt_q;

  logic                miss;
  logic [SET_W-1:0]    miss_set;
  logic [TAG_BITS-1:0] miss_tag;
  logic                beat_fire;
  logic                last_beat;

  assign miss      = fetch_req && !cache_hit;
  assign miss_set  = fetch_addr[OFFSET_BITS +: SET_W];
  assign miss_tag  = fetch_addr[ADDR_W-1 -: TAG_BITS];
  assign beat_fire = (state_q == FILL) && bus.mem_rvalid;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // Stall and the fill data path are combinational so the stall lands in the
  // miss cycle and each beat is written in the cycle it arrives.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    fetch_stall = 1'b0;
    fill_we     = 1'b0;
    fill_data   = '0;
    if (state_q != IDLE) begin
      fetch_stall = 1'b1;
    end else if (miss) begin
      fetch_stall = 1'b1;
    end
    if (beat_fire) begin
      fill_we   = 1'b1;
      fill_data = bus.mem_rdata;
    end
  end

  // Sequencer: one registered block for state, latched miss context,
  // round-robin pointers and the miss counter. Reset drops any refill in
  // flight without a tag commit, so a partially written line stays invalid.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      fill_set_q    <= '0;
      fill_way_q    <= '0;
      fill_tag_q    <= '0;
      fill_tag_we_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      miss_cnt_q    <= '0;
      // NOTE: the pointer array is a small flop bank, not a RAM, so it is
      // reset like any other register; a RAM here could not be cleared.
      for (int s = 0; s < SETS; s++) begin
        rr_ptr_q[s] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          fill_tag_we_q <= 1'b0;
          if (miss) begin
            fill_tag_q <= miss_tag;
            fill_set_q <= miss_set;
            fill_way_q <= rr_ptr_q[miss_set];
            mem_addr_q <= fetch_addr & LINE_MASK;
            mem_req_q  <= 1'b1;
            if (miss_cnt_q != '1) begin
              miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            state_q <= REQ;
          end
        end

        REQ: begin
          // Beats cannot arrive before the cycle after gnt, so any rvalid
          // here is ignored.
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= FILL;
          end
        end

        FILL: begin
          if (bus.mem_rvalid) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (last_beat) begin
              fill_tag_we_q <= 1'b1;
              state_q       <= COMMIT;
            end
          end
        end

        COMMIT: begin
          fill_tag_we_q        <= 1'b0;
          rr_ptr_q[fill_set_q] <= rr_ptr_q[fill_set_q] + WAY_W'(1);
          state_q              <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign fill_set     = fill_set_q;
  assign fill_way     = fill_way_q;
  assign fill_word    = beat_q;
  assign fill_tag     = fill_tag_q;
  assign fill_tag_we  = fill_tag_we_q;
  assign miss_count   = miss_cnt_q;

endmodule : icache_refill_ctrl

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
//
// Directed + randomized bench for icache_refill_ctrl. The bench plays the
// memory side cycle by cycle and keeps its own view of the expected cache
// state: per-set victim pointers and the miss count.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        cache_hit;
  logic        fetch_stall;
  logic        fill_we;
  logic [5:0]  fill_set;
  logic [2:0]  fill_way;
  logic [2:0]  fill_word;
  logic [63:0] fill_data;
  logic        fill_tag_we;
  logic [19:0] fill_tag;
  logic [31:0] miss_count;

  icache_refill_ctrl_if #(.ADDR_W(32)) mem_bus ();

  icache_refill_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .cache_hit   (cache_hit),
    .fetch_stall (fetch_stall),
    .bus         (mem_bus),
    .fill_we     (fill_we),
    .fill_set    (fill_set),
    .fill_way    (fill_way),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .fill_tag_we (fill_tag_we),
    .fill_tag    (fill_tag),
    .miss_count  (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference view of the cache controller.
  logic [2:0]  ref_rr [64];
  logic [31:0] ref_misses;

  task automatic ref_reset();
    for (int s = 0; s < 64; s++) ref_rr[s] = 3'd0;
    ref_misses = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // During a refill, fetch-side inputs are either quiet or scrambled; the
  // controller must ignore them either way.
  task automatic fetch_noise(input bit toggle);
    if (toggle) begin
      fetch_req  = 1'($urandom);
      fetch_addr = $urandom;
      cache_hit  = 1'($urandom);
    end else begin
      fetch_req = 1'b0;
      cache_hit = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  fetch_stall,       0);
    chk({tag, "_req"},    mem_bus.mem_req,   0);
    chk({tag, "_maddr"},  mem_bus.mem_addr,  0);
    chk({tag, "_we"},     fill_we,           0);
    chk({tag, "_set"},    fill_set,          0);
    chk({tag, "_way"},    fill_way,          0);
    chk({tag, "_word"},   fill_word,         0);
    chk({tag, "_data"},   fill_data,         0);
    chk({tag, "_tagwe"},  fill_tag_we,       0);
    chk({tag, "_tag"},    fill_tag,          0);
    chk({tag, "_mcount"}, miss_count,        0);
  endtask

  // One complete miss: miss cycle, gnt after gnt_delay wait cycles, 8 beats
  // with one idle cycle after each beat i where gap_mask[i] is set, commit,
  // then a hitting refetch. abort_beat >= 0 asserts reset right after that
  // beat instead of finishing the refill.
  task automatic do_miss(input logic [31:0] addr, input int gnt_delay,
                         input logic [7:0] gap_mask, input logic [63:0] data_base,
                         input bit toggle, input int abort_beat);
    logic [5:0]  e_set;
    logic [2:0]  e_way;
    logic [19:0] e_tag;
    logic [31:0] e_maddr;
    int          stall_cycles;
    int          pulses;
    int          b;
    e_set        = addr[11:6];
    e_way        = ref_rr[e_set];
    e_tag        = addr[31:12];
    e_maddr      = addr & 32'hFFFF_FFC0;
    stall_cycles = 0;
    pulses       = 0;

    // Miss cycle: stall must be up before any register changes.
    @(negedge clk);
    fetch_req          = 1'b1;
    fetch_addr         = addr;
    cache_hit          = 1'b0;
    mem_bus.mem_gnt    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    #1;
    chk("miss_stall", fetch_stall, 1);
    chk("miss_noreq", mem_bus.mem_req, 0);
    if (fetch_stall) stall_cycles++;
    if (ref_misses != 32'hFFFF_FFFF) ref_misses++;

    // Request phase: request and address held until gnt; stray rvalid ignored.
    for (int d = 0; d <= gnt_delay; d++) begin
      @(negedge clk);
      fetch_noise(toggle);
      mem_bus.mem_gnt    = (d == gnt_delay);
      mem_bus.mem_rvalid = 1'($urandom);
      mem_bus.mem_rdata  = {$urandom, $urandom};
      #1;
      chk("req_req",   mem_bus.mem_req,  1);
      chk("req_addr",  mem_bus.mem_addr, e_maddr);
      chk("req_we",    fill_we,          0);
      if (fetch_stall) stall_cycles++;
    end

    // Data phase.
    b = 0;
    while (b < 8) begin
      @(negedge clk);
      fetch_noise(toggle);
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = data_base + 64'(b);
      #1;
      chk("fill_we",    fill_we,         1);
      chk("fill_word",  fill_word,       b);
      chk("fill_data",  fill_data,       data_base + 64'(b));
      chk("fill_set",   fill_set,        e_set);
      chk("fill_way",   fill_way,        e_way);
      chk("fill_tag",   fill_tag,        e_tag);
      chk("fill_noreq", mem_bus.mem_req, 0);
      chk("fill_tagwe", fill_tag_we,     0);
      if (fill_we) pulses++;
      if (fetch_stall) stall_cycles++;

      if (b == abort_beat) begin
        @(negedge clk);
        rst                = 1'b0;
        fetch_req          = 1'b0;
        cache_hit          = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = {$urandom, $urandom};
        #1;
        ref_reset();
        chk_all_zero("abort");
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        #1;
        chk("abort_hold_tagwe", fill_tag_we, 0);
        rst = 1'b1;
        return;
      end

      if (gap_mask[b] && b < 7) begin
        @(negedge clk);
        fetch_noise(toggle);
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = {$urandom, $urandom};
        #1;
        chk("gap_we",    fill_we,     0);
        chk("gap_tagwe", fill_tag_we, 0);
        if (fetch_stall) stall_cycles++;
      end
      b++;
    end

    // Commit cycle; an extra beat here must be ignored.
    @(negedge clk);
    fetch_noise(toggle);
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = {$urandom, $urandom};
    #1;
    chk("commit_tagwe", fill_tag_we, 1);
    chk("commit_tag",   fill_tag,    e_tag);
    chk("commit_set",   fill_set,    e_set);
    chk("commit_way",   fill_way,    e_way);
    chk("commit_we",    fill_we,     0);
    chk("commit_stall", fetch_stall, 1);
    chk("fill_pulses",  pulses,      8);
    if (fetch_stall) stall_cycles++;
    ref_rr[e_set] = e_way + 3'd1;

    // Back in idle: refetch hits, stall released, late beat still ignored.
    @(negedge clk);
    fetch_req          = 1'b1;
    fetch_addr         = addr;
    cache_hit          = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    #1;
    chk("post_stall",   fetch_stall,     0);
    chk("post_tagwe",   fill_tag_we,     0);
    chk("post_we",      fill_we,         0);
    chk("post_req",     mem_bus.mem_req, 0);
    chk("miss_count",   miss_count,      ref_misses);
    chk("stall_cycles", stall_cycles,    3 + gnt_delay + 8 + $countones(gap_mask[6:0]));
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    fetch_req          = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst                = 1'b0;
    fetch_req          = 1'b0;
    fetch_addr         = 32'd0;
    cache_hit          = 1'b0;
    mem_bus.mem_gnt    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 64'd0;
    ref_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Hits and idle cycles must never stall or request.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fetch_req  = (i != 3);
      cache_hit  = (i != 3) ? 1'b1 : 1'b0;
      fetch_addr = $urandom;
      #1;
      chk("hit_stall", fetch_stall,     0);
      chk("hit_req",   mem_bus.mem_req, 0);
    end
    @(negedge clk);
    fetch_req = 1'b0;
    #1;
    chk("hit_mcount", miss_count, 0);

    // Cold miss, zero-wait memory: set 0x29, way 0, tag 0x00001, 11-cycle stall.
    do_miss(32'h0000_1A40, 0, 8'h00, 64'h10, 1'b0, -1);

    // Grant delayed 5 cycles, gaps after beats 2 and 5.
    do_miss($urandom, 5, 8'b0010_0100, {$urandom, $urandom}, 1'b0, -1);

    // Nine misses to set 0x05 (round-robin wrap) with one set-0x06 miss between.
    for (int i = 0; i < 9; i++) begin
      a = {20'(i + 32'h300), 6'h05, 6'($urandom)};
      do_miss(a, int'($urandom_range(0, 2)), 8'($urandom), {$urandom, $urandom}, 1'b0, -1);
      if (i == 3) begin
        a = {20'h7_7777, 6'h06, 6'($urandom)};
        do_miss(a, 0, 8'h00, {$urandom, $urandom}, 1'b0, -1);
      end
    end

    // Fetch inputs thrashing during the refill must not disturb it.
    do_miss($urandom, 1, 8'($urandom), {$urandom, $urandom}, 1'b1, -1);

    // Reset after beat 4, then a fresh miss restarts at beat 0 in way 0.
    do_miss({20'h0_ABCD, 6'h05, 6'h08}, 0, 8'h00, {$urandom, $urandom}, 1'b0, 4);
    do_miss({20'h0_ABCE, 6'h05, 6'h10}, 0, 8'h00, {$urandom, $urandom}, 1'b0, -1);

    // Miss counter saturation.
    @(negedge clk);
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.miss_cnt_q;
    ref_misses = 32'hFFFF_FFFF;
    #1;
    chk("sat_preload", miss_count, 32'hFFFF_FFFF);
    do_miss($urandom, 0, 8'h00, {$urandom, $urandom}, 1'b0, -1);

    // Randomized misses.
    for (int i = 0; i < 20; i++) begin
      do_miss($urandom, int'($urandom_range(0, 3)), 8'($urandom),
              {$urandom, $urandom}, 1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_icache_refill_ctrl

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss/refill sequencer for the 8-way, 64-set, 64 B-line instruction cache in the IF stage.
- On a fetch miss it stalls fetch and issues a line-aligned 8-beat burst read to the memory bus.
- Each returning 64-bit beat is written into the chosen way. Tag and valid are committed after the last beat, then fetch is released.
- Victim selection is per-set round-robin.

Parameters:
- ADDR_W, 32, byte address width
- SETS, 64, number of cache sets
- WAYS, 8, associativity
- OFFSET_BITS, 6, line offset bits (64 B line)
- BEATS, 8, 64-bit bus beats per line
- TAG_BITS, ADDR_W-6-OFFSET_BITS, tag width (derived)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- fetch_req  in  1  IF fetch request this cycle
- fetch_addr  in  ADDR_W  fetch byte address
- cache_hit  in  1  combinational hit from cache tag compare
- fetch_stall  out  1  hold PC/IF pipeline
- mem_req  out  1  burst read request
- mem_addr  out  ADDR_W  line-aligned burst base address
- mem_gnt  in  1  memory accepts request
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  64  read beat data
- fill_we  out  1  write one data word into cache
- fill_set  out  log2(SETS)  target set
- fill_way  out  log2(WAYS)  target way
- fill_word  out  log2(BEATS)  word index within line
- fill_data  out  64  word data
- fill_tag_we  out  1  commit tag and set valid for (fill_set, fill_way)
- fill_tag  out  TAG_BITS  tag to commit
- miss_count  out  32  saturating miss counter

Behaviour:
- Reset values, asynchronous on rst low:
  - state=IDLE
  - fetch_stall, mem_req, fill_we and fill_tag_we = 0
  - mem_addr, fill_set, fill_way, fill_word, fill_data, fill_tag = 0
  - all per-set RR pointers = 0; beat counter = 0; miss_count = 0
- Miss detect: miss = fetch_req && !cache_hit, sampled only in IDLE.
- fetch_stall = (state==IDLE && miss) || state!=IDLE. It is combinational so the stall takes effect in the miss cycle.
- IDLE: on miss, latch tag=fetch_addr[ADDR_W-1:12], set=fetch_addr[11:6] and way=rr_ptr[set].
  - mem_addr = {fetch_addr[ADDR_W-1:6], 6'b0}.
  - Increment miss_count, saturating at 0xFFFFFFFF.
  - Next state is REQ.
- REQ: mem_req=1 and mem_addr is held stable until mem_gnt.
  - On mem_gnt go to FILL, with mem_req dropping the next cycle. beat=0.
  - mem_rvalid seen in REQ is ignored. The bus contract is that the first rvalid comes no earlier than the cycle after gnt.
- FILL: each mem_rvalid cycle drives fill_we=1, fill_word=beat and fill_data=mem_rdata in the same cycle (combinational pass-through), then beat increments.
  - Gaps where rvalid=0 are allowed; fill_we=0 during a gap.
  - On the rvalid that has beat==BEATS-1, go to COMMIT.
- COMMIT, 1 cycle: fill_tag_we=1 with the latched fill_tag, fill_set and fill_way.
  - rr_ptr[set] advances by 1 modulo WAYS, wrapping from 7 to 0.
  - Next state is IDLE.
- IDLE after COMMIT: fetch_stall drops once the cache re-evaluates the hit. A refetch of the same address then hits, adding 1 cycle of refill-to-use latency.
- fill_set, fill_way and fill_tag stay stable from IDLE exit until COMMIT completes. fetch_addr and fetch_req changes during a refill are ignored.
- Latency: miss cycle + REQ (≥1) + BEATS data cycles + COMMIT. The minimum miss penalty is 11 cycles with zero-wait gnt and back-to-back rvalid.
- Tag/valid ordering: valid is never set before all 8 words are written, so a partially filled line cannot hit.
- Reset mid-refill returns to IDLE immediately, with no tag commit.
  - Partially written words are harmless because valid is not set.
  - The memory side must also be reset.
- Extra mem_rvalid after the last beat, while in COMMIT or IDLE, is ignored.

Test Plan:
- Cold miss, fetch_addr=0x0000_1A40, zero-wait memory, beats 0x10..0x17 -> mem_addr=0x0000_1A40, set=0x29, way=0, fill_word 0..7 with matching data, fill_tag_we with tag=0x00001, stall released after 11 cycles, miss_count=1.
- Gnt delayed 5 cycles, rvalid gaps after beats 2 and 5 -> mem_req and mem_addr held through the delay, no fill_we during gaps, exactly 8 fill_we pulses, then COMMIT.
- Nine misses to set 0x05 with distinct tags -> ways 0,1,...,7,0 selected in order (RR wrap). A miss in set 0x06 in between uses way 0, showing per-set pointers are independent.
- fetch_req with cache_hit=1 in IDLE -> no stall, mem_req stays 0, miss_count unchanged. fetch_addr toggling during FILL -> latched set/tag unchanged.
- rst asserted after beat 4 -> all outputs 0 in the same cycle, no fill_tag_we. A fresh miss after reset starts at beat 0 with way 0.
- Preload miss_count=0xFFFFFFFF via force, then a miss -> miss_count stays 0xFFFFFFFF.
